multicycle_control_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I-subset datapath: PC, instruction register, register file, immediate generator, ALU and a single shared memory port. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with memory via a ready signal, and times out stalled accesses. It also flags illegal opcodes and counts retired instructions. It replaces per-instruction combinational control so that instruction and data memory can share one port.

---
 rtl/multicycle_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for an RV32I-subset datapath sharing one memory port.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and traps on illegal opcodes or stalled accesses.
module multicycle_control_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [3:0]  alu_control,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_error,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // The last wait cycle: a miss here would push the count to TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [6:0]  opcode_reg;
  logic [2:0]  funct3_reg;
  logic        f7b5_reg;
  logic [7:0]  tmo_cnt_reg;
  logic        illegal_reg, bus_error_reg;
  logic [31:0] instret_reg;

  logic        retire, set_illegal, set_bus_error, timeout_hit, dec_legal;
  logic [3:0]  alu_dec;
  logic [2:0]  dec_f3;
  logic        unused_instr_bits;

  assign dec_f3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign timeout_hit       = !mem_ready && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    dec_legal = 1'b0;
    case (instr[6:0])
      OP_R, OP_I:   dec_legal = (dec_f3 == 3'b000) || (dec_f3 == 3'b010) ||
                                (dec_f3 == 3'b110) || (dec_f3 == 3'b111);
      OP_LW, OP_SW: dec_legal = 1'b1;
      OP_BR:        dec_legal = (dec_f3[2:1] == 2'b00);
      default:      dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3_reg)
      3'b000:  alu_dec = (opcode_reg == OP_R && f7b5_reg) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    alu_control   = ALU_AND;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    // Controls are forced low while reset is held so an in-flight access drops at once.
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end else if (timeout_hit) begin
            set_bus_error = 1'b1;
            state_next    = S_TRAP;
          end
        end
        S_DECODE: begin
          if (dec_legal) begin
            state_next = S_EXEC;
          end else begin
            set_illegal = 1'b1;
            state_next  = S_TRAP;
          end
        end
        S_EXEC: begin
          case (opcode_reg)
            OP_R: begin
              alu_control = alu_dec;
              state_next  = S_WB;
            end
            OP_I: begin
              alu_src     = 1'b1;
              alu_control = alu_dec;
              state_next  = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src     = 1'b1;
              alu_control = ALU_ADD;
              state_next  = S_MEM;
            end
            OP_BR: begin
              alu_control = ALU_SUB;
              if ((funct3_reg == 3'b000 && zero) || (funct3_reg == 3'b001 && !zero)) begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
              end
              retire     = 1'b1;
              state_next = S_FETCH;
            end
            default: state_next = S_TRAP;
          endcase
        end
        S_MEM: begin
          iord        = 1'b1;
          alu_src     = 1'b1;
          alu_control = ALU_ADD;
          if (opcode_reg == OP_LW) mem_read = 1'b1;
          else                     mem_write = !timeout_hit;
          if (mem_ready) begin
            state_next = (opcode_reg == OP_LW) ? S_WB : S_FETCH;
            retire     = (opcode_reg != OP_LW);
          end else if (timeout_hit) begin
            set_bus_error = 1'b1;
            state_next    = S_TRAP;
          end
        end
        S_WB: begin
          reg_write   = 1'b1;
          mem_to_reg  = (opcode_reg == OP_LW);
          alu_src     = (opcode_reg != OP_R);
          alu_control = (opcode_reg == OP_LW) ? ALU_ADD : alu_dec;
          retire      = 1'b1;
          state_next  = S_FETCH;
        end
        S_TRAP:  state_next = S_TRAP;
        default: state_next = S_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      opcode_reg    <= '0;
      funct3_reg    <= '0;
      f7b5_reg      <= 1'b0;
      tmo_cnt_reg   <= '0;
      illegal_reg   <= 1'b0;
      bus_error_reg <= 1'b0;
      instret_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        opcode_reg <= instr[6:0];
        funct3_reg <= instr[14:12];
        f7b5_reg   <= instr[30];
      end
      if (state_next != state_reg && (state_next == S_FETCH || state_next == S_MEM))
        tmo_cnt_reg <= '0;
      else if ((state_reg == S_FETCH || state_reg == S_MEM) && !mem_ready)
        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
      if (set_illegal)   illegal_reg   <= 1'b1;
      if (set_bus_error) bus_error_reg <= 1'b1;
      if (retire)        instret_reg   <= instret_reg + 32'd1;
    end
  end

  assign state     = state_reg;
  assign illegal   = illegal_reg;
  assign bus_error = bus_error_reg;
  assign instret   = instret_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: each scenario queues per-cycle stimulus with the expected state,
// control vector and retire count, then replays the queue against the sequencer.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, iord, ir_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, alu_src;
  logic [3:0]  alu_control;
  logic [2:0]  state;
  logic        illegal, bus_error;
  logic [31:0] instret;
  logic [12:0] ctl_obs;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_control(alu_control), .state(state), .illegal(illegal),
    .bus_error(bus_error), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src, alu_control}
  assign ctl_obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src,
                    reg_write, mem_to_reg, alu_src, alu_control};

  localparam logic [12:0] C_NONE   = 13'b0_0_0_0_0_0_0_0_0_0000;
  localparam logic [12:0] C_FGO    = 13'b1_0_0_1_1_0_0_0_0_0000;
  localparam logic [12:0] C_FWAIT  = 13'b1_0_0_0_0_0_0_0_0_0000;
  localparam logic [12:0] C_EX_ADD = 13'b0_0_0_0_0_0_0_0_0_0010;
  localparam logic [12:0] C_WB_ADD = 13'b0_0_0_0_0_0_1_0_0_0010;
  localparam logic [12:0] C_EX_SUB = 13'b0_0_0_0_0_0_0_0_0_0110;
  localparam logic [12:0] C_WB_SUB = 13'b0_0_0_0_0_0_1_0_0_0110;
  localparam logic [12:0] C_EX_ORI = 13'b0_0_0_0_0_0_0_0_1_0001;
  localparam logic [12:0] C_WB_ORI = 13'b0_0_0_0_0_0_1_0_1_0001;
  localparam logic [12:0] C_EX_MEM = 13'b0_0_0_0_0_0_0_0_1_0010;
  localparam logic [12:0] C_MEM_LW = 13'b1_0_1_0_0_0_0_0_1_0010;
  localparam logic [12:0] C_WB_LW  = 13'b0_0_0_0_0_0_1_1_1_0010;
  localparam logic [12:0] C_MEM_SW = 13'b0_1_1_0_0_0_0_0_1_0010;
  localparam logic [12:0] C_BR_T   = 13'b0_0_0_0_1_1_0_0_0_0110;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_ORI = 32'h0050E193;
  localparam logic [31:0] I_LW  = 32'h0000A183;
  localparam logic [31:0] I_SW  = 32'h0020A023;
  localparam logic [31:0] I_BEQ = 32'h00208063;
  localparam logic [31:0] I_BNE = 32'h00209063;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

  typedef struct packed {
    logic [31:0] ins;
    logic        rdy;
    logic        z;
    logic [2:0]  st;
    logic [12:0] ctl;
    logic [31:0] ret;
  } item_t;

  item_t sb[$];

  task automatic push(input logic [31:0] ins, input logic rdy, input logic z,
                      input logic [2:0] st, input logic [12:0] ctl, input logic [31:0] ret);
    item_t it;
    it.ins = ins; it.rdy = rdy; it.z = z; it.st = st; it.ctl = ctl; it.ret = ret;
    sb.push_back(it);
  endtask

  task automatic apply_reset;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({state, ctl_obs} !== {3'd0, C_NONE}) begin
      errors++;
      $display("FAIL reset_ctl: state=%0d ctl=%b want state=0 ctl=%b", state, ctl_obs, C_NONE);
    end
    checks++;
    if ({instret, illegal, bus_error} !== {32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags: instret=%0d illegal=%b bus_error=%b want 0 0 0",
               instret, illegal, bus_error);
    end
    $display("reset: state=%0d ctl=%b instret=%0d", state, ctl_obs, instret);
    #1 reset = 1'b0;
  endtask

  task automatic test_add;
    item_t it;
    int n = 0;
    apply_reset();
    push(I_ADD, 1, 0, 3'd0, C_FGO,    0);
    push(I_ADD, 1, 0, 3'd1, C_NONE,   0);
    push(I_ADD, 1, 0, 3'd2, C_EX_ADD, 0);
    push(I_ADD, 1, 0, 3'd4, C_WB_ADD, 0);
    push(I_ADD, 0, 0, 3'd0, C_FWAIT,  1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      instr = it.ins; mem_ready = it.rdy; zero = it.z;
      @(negedge clk);
      checks++;
      if ({state, ctl_obs, instret} !== {it.st, it.ctl, it.ret}) begin
        errors++;
        $display("FAIL add c%0d: state=%0d ctl=%b instret=%0d want %0d %b %0d",
                 n, state, ctl_obs, instret, it.st, it.ctl, it.ret);
      end else $display("add c%0d: state=%0d ctl=%b instret=%0d", n, state, ctl_obs, instret);
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    item_t it;
    int n = 0;
    apply_reset();
    push(I_SUB, 1, 0, 3'd0, C_FGO,    0);
    push(I_SUB, 1, 0, 3'd1, C_NONE,   0);
    push(I_SUB, 1, 0, 3'd2, C_EX_SUB, 0);
    push(I_SUB, 1, 0, 3'd4, C_WB_SUB, 0);
    push(I_ORI, 1, 0, 3'd0, C_FGO,    1);
    push(I_ORI, 1, 0, 3'd1, C_NONE,   1);
    push(I_ORI, 1, 0, 3'd2, C_EX_ORI, 1);
    push(I_ORI, 1, 0, 3'd4, C_WB_ORI, 1);
    push(I_ORI, 0, 0, 3'd0, C_FWAIT,  2);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      instr = it.ins; mem_ready = it.rdy; zero = it.z;
      @(negedge clk);
      checks++;
      if ({state, ctl_obs, instret} !== {it.st, it.ctl, it.ret}) begin
        errors++;
        $display("FAIL b2b c%0d: state=%0d ctl=%b instret=%0d want %0d %b %0d",
                 n, state, ctl_obs, instret, it.st, it.ctl, it.ret);
      end else $display("b2b c%0d: state=%0d ctl=%b instret=%0d", n, state, ctl_obs, instret);
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall;
    item_t it;
    int n = 0;
    apply_reset();
    push(I_LW, 1, 0, 3'd0, C_FGO,    0);
    push(I_LW, 0, 0, 3'd1, C_NONE,   0);
    push(I_LW, 0, 0, 3'd2, C_EX_MEM, 0);
    for (int k = 0; k < 3; k++) push(I_LW, 0, 0, 3'd3, C_MEM_LW, 0);
    push(I_LW, 1, 0, 3'd3, C_MEM_LW, 0);
    push(I_LW, 0, 0, 3'd4, C_WB_LW,  0);
    push(I_LW, 0, 0, 3'd0, C_FWAIT,  1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      instr = it.ins; mem_ready = it.rdy; zero = it.z;
      @(negedge clk);
      checks++;
      if ({state, ctl_obs, instret} !== {it.st, it.ctl, it.ret}) begin
        errors++;
        $display("FAIL lw c%0d: state=%0d ctl=%b instret=%0d want %0d %b %0d",
                 n, state, ctl_obs, instret, it.st, it.ctl, it.ret);
      end else $display("lw c%0d: state=%0d ctl=%b instret=%0d", n, state, ctl_obs, instret);
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    item_t it;
    int n = 0;
    apply_reset();
    push(I_BEQ, 1, 1, 3'd0, C_FGO,    0);
    push(I_BEQ, 1, 1, 3'd1, C_NONE,   0);
    push(I_BEQ, 1, 1, 3'd2, C_BR_T,   0);
    push(I_BNE, 1, 1, 3'd0, C_FGO,    1);
    push(I_BNE, 1, 1, 3'd1, C_NONE,   1);
    push(I_BNE, 1, 1, 3'd2, C_EX_SUB, 1);
    push(I_BNE, 0, 1, 3'd0, C_FWAIT,  2);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      instr = it.ins; mem_ready = it.rdy; zero = it.z;
      @(negedge clk);
      checks++;
      if ({state, ctl_obs, instret} !== {it.st, it.ctl, it.ret}) begin
        errors++;
        $display("FAIL branch c%0d: state=%0d ctl=%b instret=%0d want %0d %b %0d",
                 n, state, ctl_obs, instret, it.st, it.ctl, it.ret);
      end else $display("branch c%0d: state=%0d ctl=%b instret=%0d", n, state, ctl_obs, instret);
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Runs straight after test_branch, so the retire count of 2 must survive the trap.
  task automatic test_illegal;
    item_t it;
    int n = 0;
    push(I_BAD, 1, 0, 3'd0, C_FGO,  2);
    push(I_BAD, 1, 0, 3'd1, C_NONE, 2);
    for (int k = 0; k < 20; k++) push(I_BAD, 1, 0, 3'd5, C_NONE, 2);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      instr = it.ins; mem_ready = it.rdy; zero = it.z;
      @(negedge clk);
      checks++;
      if ({state, ctl_obs, instret} !== {it.st, it.ctl, it.ret}) begin
        errors++;
        $display("FAIL illegal c%0d: state=%0d ctl=%b instret=%0d want %0d %b %0d",
                 n, state, ctl_obs, instret, it.st, it.ctl, it.ret);
      end else $display("illegal c%0d: state=%0d ctl=%b instret=%0d", n, state, ctl_obs, instret);
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if ({illegal, bus_error} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_flag: illegal=%b bus_error=%b want 1 0", illegal, bus_error);
    end
    apply_reset();
    checks++;
    if ({illegal, state} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL illegal_clear: illegal=%b state=%0d want 0 0", illegal, state);
    end else $display("illegal_clear: illegal=%b state=%0d", illegal, state);
  endtask

  task automatic test_timeout;
    item_t it;
    int n = 0;
    apply_reset();
    for (int k = 0; k < 16; k++) push(I_ADD, 0, 0, 3'd0, C_FWAIT, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      instr = it.ins; mem_ready = it.rdy; zero = it.z;
      @(negedge clk);
      checks++;
      if ({state, ctl_obs, instret} !== {it.st, it.ctl, it.ret}) begin
        errors++;
        $display("FAIL tmo c%0d: state=%0d ctl=%b instret=%0d want %0d %b %0d",
                 n, state, ctl_obs, instret, it.st, it.ctl, it.ret);
      end else $display("tmo c%0d: state=%0d ctl=%b", n, state, ctl_obs);
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if ({state, bus_error, mem_read} !== {3'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tmo_trap: state=%0d bus_error=%b mem_read=%b want 5 1 0",
               state, bus_error, mem_read);
    end
    apply_reset();
    n = 0;
    for (int k = 0; k < 15; k++) push(I_ADD, 0, 0, 3'd0, C_FWAIT, 0);
    push(I_ADD, 1, 0, 3'd0, C_FGO,  0);
    push(I_ADD, 0, 0, 3'd1, C_NONE, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      instr = it.ins; mem_ready = it.rdy; zero = it.z;
      @(negedge clk);
      checks++;
      if ({state, ctl_obs, instret} !== {it.st, it.ctl, it.ret}) begin
        errors++;
        $display("FAIL tmo_edge c%0d: state=%0d ctl=%b instret=%0d want %0d %b %0d",
                 n, state, ctl_obs, instret, it.st, it.ctl, it.ret);
      end else $display("tmo_edge c%0d: state=%0d ctl=%b", n, state, ctl_obs);
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (bus_error !== 1'b0) begin
      errors++;
      $display("FAIL tmo_edge_flag: bus_error=%b want 0", bus_error);
    end
  endtask

  task automatic test_sw_reset;
    item_t it;
    int n = 0;
    apply_reset();
    push(I_SW, 1, 0, 3'd0, C_FGO,    0);
    push(I_SW, 0, 0, 3'd1, C_NONE,   0);
    push(I_SW, 0, 0, 3'd2, C_EX_MEM, 0);
    push(I_SW, 0, 0, 3'd3, C_MEM_SW, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      instr = it.ins; mem_ready = it.rdy; zero = it.z;
      @(negedge clk);
      checks++;
      if ({state, ctl_obs, instret} !== {it.st, it.ctl, it.ret}) begin
        errors++;
        $display("FAIL sw c%0d: state=%0d ctl=%b instret=%0d want %0d %b %0d",
                 n, state, ctl_obs, instret, it.st, it.ctl, it.ret);
      end else $display("sw c%0d: state=%0d ctl=%b", n, state, ctl_obs);
      n++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_write, mem_read, state} !== {1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL sw_async: mem_write=%b mem_read=%b state=%0d want 0 0 0",
               mem_write, mem_read, state);
    end else $display("sw_async: mem_write=%b state=%0d", mem_write, state);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, mem_read, instret} !== {3'd0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL sw_restart: state=%0d mem_read=%b instret=%0d want 0 1 0",
               state, mem_read, instret);
    end else $display("sw_restart: state=%0d mem_read=%b", state, mem_read);
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_timeout();
    test_sw_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
